// File: rtl/commfifo_mc_apb.sv
// rtl/commfifo_mc_apb.sv - multi-channel APB mailbox FIFOs (H2D/D2H per channel); COMMFIFO_MC_IRQ_EN enables irq
module commfifo_mc_apb_fifo #(
    parameter int DW      = 8,
    parameter int LGDEPTH = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               push,
    input  logic [DW-1:0]      wdata,
    input  logic               pop,
    output logic [DW-1:0]      head,
    output logic [LGDEPTH:0]   count,
    output logic               not_full,
    output logic               not_empty,
    output logic               drop,
    output logic               starve
);
    localparam int DEPTH = 1 << LGDEPTH;
    localparam logic [LGDEPTH:0] FULL_CNT = {1'b1, {LGDEPTH{1'b0}}};

    logic [DW-1:0]      mem [DEPTH];
    logic [LGDEPTH-1:0] wr_ptr;
    logic [LGDEPTH-1:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign not_empty = (count != '0);
    assign not_full  = (count != FULL_CNT);
    // a pop frees a slot this cycle, so a push into a full FIFO still lands
    assign do_pop    = pop & not_empty;
    assign do_push   = push & (not_full | do_pop);
    assign drop      = push & ~do_push;
    assign starve    = pop & ~not_empty;
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + LGDEPTH'(1);
            if (do_pop)  rd_ptr <= rd_ptr + LGDEPTH'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (LGDEPTH+1)'(1);
                2'b01:   count <= count - (LGDEPTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

module commfifo_mc_apb #(
    parameter int NCH     = 2,
    parameter int DW      = 8,
    parameter int LGDEPTH = 6
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [11:2]       PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [NCH-1:0]    h2d_wr,
    input  logic [NCH*DW-1:0] h2d_data,
    output logic [NCH-1:0]    h2d_not_full,
    input  logic [NCH-1:0]    d2h_rd,
    output logic [NCH*DW-1:0] d2h_data,
    output logic [NCH-1:0]    d2h_not_empty,
    output logic              irq
);
    logic        access;
    logic [1:0]  ch;
    logic [1:0]  rsel;
    logic        addr_err;
    logic        ok;
    logic [31:0] rd_val [NCH];
    logic        unused_ok;

    assign access   = PSEL & PENABLE;
    assign ch       = PADDR[5:4];
    assign rsel     = PADDR[3:2];
    assign addr_err = (|PADDR[11:6]) | ({30'b0, ch} >= 32'(NCH));
    assign ok       = access & ~addr_err;
    assign PREADY   = 1'b1;
    assign PSLVERR  = access & addr_err;
    assign unused_ok = ^PWDATA;

`ifdef COMMFIFO_MC_IRQ_EN
    logic [NCH-1:0] chan_irq;
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic             hit;
        logic             clr_hit;
        logic [DW-1:0]    h2d_head;
        logic [LGDEPTH:0] h2d_cnt;
        logic [LGDEPTH:0] d2h_cnt;
        logic             h2d_ne;
        logic             d2h_nf;
        logic             h2d_drop;
        logic             h2d_starve;
        logic             d2h_drop;
        logic             d2h_starve;
        logic [2:0]       sticky;
        logic [2:0]       sticky_set;
        logic [2:0]       sticky_clr;
        logic [2:0]       en;
        logic             unused_ch;

        assign hit       = ok & (ch == 2'(c));
        assign clr_hit   = hit & PWRITE & (rsel == 2'd3);
        assign unused_ch = d2h_starve;

        commfifo_mc_apb_fifo #(.DW(DW), .LGDEPTH(LGDEPTH)) u_h2d (
            .clk       (PCLK),
            .resetn    (PRESETn),
            .push      (h2d_wr[c]),
            .wdata     (h2d_data[c*DW +: DW]),
            .pop       (hit & ~PWRITE & (rsel == 2'd0)),
            .head      (h2d_head),
            .count     (h2d_cnt),
            .not_full  (h2d_not_full[c]),
            .not_empty (h2d_ne),
            .drop      (h2d_drop),
            .starve    (h2d_starve)
        );

        commfifo_mc_apb_fifo #(.DW(DW), .LGDEPTH(LGDEPTH)) u_d2h (
            .clk       (PCLK),
            .resetn    (PRESETn),
            .push      (hit & PWRITE & (rsel == 2'd0)),
            .wdata     (PWDATA[DW-1:0]),
            .pop       (d2h_rd[c]),
            .head      (d2h_data[c*DW +: DW]),
            .count     (d2h_cnt),
            .not_full  (d2h_nf),
            .not_empty (d2h_not_empty[c]),
            .drop      (d2h_drop),
            .starve    (d2h_starve)
        );

        // sticky order matches STATUS bits 4..2; a new event outranks a W1C
        assign sticky_set = {h2d_drop, d2h_drop, h2d_starve};
        assign sticky_clr = clr_hit ? PWDATA[4:2] : 3'b000;

        always_ff @(posedge PCLK) begin
            if (!PRESETn) sticky <= '0;
            else          sticky <= (sticky & ~sticky_clr) | sticky_set;
        end

`ifdef COMMFIFO_MC_IRQ_EN
        always_ff @(posedge PCLK) begin
            if (!PRESETn)     en <= '0;
            else if (clr_hit) en <= PWDATA[10:8];
        end
        assign chan_irq[c] = |({d2h_nf & 1'b1, h2d_ne, |sticky} & {en[1], en[0], en[2]});
`else
        assign en = 3'b000;
`endif

        assign rd_val[c] = (rsel == 2'd0) ? (h2d_ne ? 32'(h2d_head) : 32'd0) :
                           (rsel == 2'd1) ? {27'b0, sticky, d2h_nf, h2d_ne} :
                           (rsel == 2'd2) ? {16'(d2h_cnt), 16'(h2d_cnt)} :
                                            {21'b0, en, 8'b0};
    end

    always_comb begin
        PRDATA = '0;
        if (ok && !PWRITE) begin
            for (int c = 0; c < NCH; c++) begin
                if (ch == c[1:0]) PRDATA = rd_val[c];
            end
        end
    end

`ifdef COMMFIFO_MC_IRQ_EN
    logic irq_q;
    always_ff @(posedge PCLK) begin
        if (!PRESETn) irq_q <= 1'b0;
        else          irq_q <= |chan_irq;
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_commfifo_mc_apb.sv
// tb/tb_commfifo_mc_apb.sv - scoreboard bench for commfifo_mc_apb (NCH=2, DW=8, LGDEPTH=2)
module tb_commfifo_mc_apb;
    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [11:2] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [1:0]  h2d_wr;
    logic [15:0] h2d_data;
    logic [1:0]  h2d_not_full;
    logic [1:0]  d2h_rd;
    logic [15:0] d2h_data;
    logic [1:0]  d2h_not_empty;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] exp_q[$];
    string       tag_q[$];
    logic [7:0]  d2h_q0[$];

    always #5 PCLK = ~PCLK;

    commfifo_mc_apb #(.NCH(2), .DW(8), .LGDEPTH(2)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .h2d_wr(h2d_wr), .h2d_data(h2d_data), .h2d_not_full(h2d_not_full),
        .d2h_rd(d2h_rd), .d2h_data(d2h_data), .d2h_not_empty(d2h_not_empty), .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: APB access phases and host D2H pops are checked against queued expectations
    always @(negedge PCLK) begin : mon
        logic [32:0] e;
        string t;
        if (PRESETn) begin
            if (PSEL && PENABLE) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL apb_unexpected: access with no expectation, prdata 0x%0h", PRDATA);
                end else begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    check({t, " prdata"}, PRDATA, e[31:0]);
                    check({t, " pslverr"}, {31'b0, PSLVERR}, {31'b0, e[32]});
                    check({t, " pready"}, {31'b0, PREADY}, 32'd1);
                end
            end else begin
                check("idle_prdata", PRDATA, 32'd0);
                check("idle_pslverr", {31'b0, PSLVERR}, 32'd0);
            end
            if (d2h_rd[0] && d2h_not_empty[0]) begin
                if (d2h_q0.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL d2h_unexpected: pop with no expectation, data 0x%0h", d2h_data[7:0]);
                end else begin
                    check("d2h_pop", {24'b0, d2h_data[7:0]}, {24'b0, d2h_q0.pop_front()});
                end
            end
        end
    end

    task automatic apb(input logic wr, input logic [9:0] wa, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input string tag);
        exp_q.push_back({ee, er});
        tag_q.push_back(tag);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = wa; PWDATA = wd;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    endtask

    task automatic rd(input int c, input int r, input logic [31:0] e, input string tag);
        apb(1'b0, {6'b0, 2'(c), 2'(r)}, 32'd0, e, 1'b0, tag);
    endtask

    task automatic wr(input int c, input int r, input logic [31:0] d, input string tag);
        apb(1'b1, {6'b0, 2'(c), 2'(r)}, d, 32'd0, 1'b0, tag);
    endtask

    task automatic hpush(input int c, input logic [7:0] v, input int d);
        repeat (d) begin @(posedge PCLK); #1; end
        h2d_wr[c] = 1'b1;
        h2d_data[c*8 +: 8] = v;
        @(posedge PCLK); #1;
        h2d_wr[c] = 1'b0;
    endtask

    task automatic hpop(input int c, input int d);
        repeat (d) begin @(posedge PCLK); #1; end
        d2h_rd[c] = 1'b1;
        @(posedge PCLK); #1;
        d2h_rd[c] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        h2d_wr = '0; h2d_data = '0; d2h_rd = '0;
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_h2d_not_full", {30'b0, h2d_not_full}, 32'h3);
        check("rst_d2h_not_empty", {30'b0, d2h_not_empty}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        PRESETn = 1'b1;
        rd(0, 1, 32'h02, "rst_status0");
        rd(0, 2, 32'h0, "rst_level0");
        rd(1, 3, 32'h0, "rst_ctrl1");

        // host fills ch1 H2D, fifth push dropped
        for (int i = 0; i < 4; i++) hpush(1, 8'(17 * (i + 1)), 1);
        check("h2d_full_flag", {30'b0, h2d_not_full}, 32'h1);
        hpush(1, 8'h55, 1);
        rd(1, 1, 32'h13, "status_hover");
        rd(1, 2, 32'h4, "level_h2d4");
        for (int i = 0; i < 4; i++) rd(1, 0, 32'(17 * (i + 1)), "h2d_order");
        rd(1, 1, 32'h12, "status_drained");
        wr(1, 3, 32'h10, "w1c_hover");
        rd(1, 1, 32'h02, "status_hover_clr");
        check("h2d_room_again", {30'b0, h2d_not_full}, 32'h3);

        // APB push to D2H, host pop
        d2h_q0.push_back(8'hA5);
        wr(0, 0, 32'h1A5, "d2h_push");
        check("d2h_valid", {30'b0, d2h_not_empty}, 32'h1);
        check("d2h_head", {24'b0, d2h_data[7:0]}, 32'hA5);
        hpop(0, 1);
        check("d2h_empty", {30'b0, d2h_not_empty}, 32'h0);

        // underflow and its W1C
        rd(0, 0, 32'h0, "rd_empty");
        rd(0, 1, 32'h06, "status_under");
        wr(0, 3, 32'h04, "w1c_under");
        rd(0, 1, 32'h02, "status_under_clr");

        // D2H full, overflow, then push+pop on full
        for (int i = 1; i <= 4; i++) begin
            d2h_q0.push_back(8'(i));
            wr(0, 0, 32'(i), "d2h_fill");
        end
        wr(0, 0, 32'hEE, "d2h_overflow");
        rd(0, 1, 32'h08, "status_dover");
        rd(0, 2, 32'h0004_0000, "level_d2h4");
        wr(0, 3, 32'h08, "w1c_dover");
        rd(0, 1, 32'h00, "status_full_clr");
        d2h_q0.push_back(8'h05);
        fork
            wr(0, 0, 32'h05, "push_pop_full");
            hpop(0, 2);
        join
        rd(0, 2, 32'h0004_0000, "level_still4");
        rd(0, 1, 32'h00, "no_dover");
        repeat (4) hpop(0, 1);
        check("d2h_drained", {30'b0, d2h_not_empty}, 32'h0);

        // decode errors have no side effect
        apb(1'b0, 10'h008, 32'h0, 32'h0, 1'b1, "err_ch2_rd");
        apb(1'b1, 10'h008, 32'h77, 32'h0, 1'b1, "err_ch2_wr");
        apb(1'b0, 10'h040, 32'h0, 32'h0, 1'b1, "err_hi_rd");
        rd(0, 2, 32'h0, "err_nochange_level");
        rd(0, 1, 32'h02, "err_nochange_status");
        check("err_d2h_untouched", {30'b0, d2h_not_empty}, 32'h0);

`ifdef COMMFIFO_MC_IRQ_EN
        wr(1, 3, 32'h100, "ctrl_en");
        rd(1, 3, 32'h100, "ctrl_en_rb");
        hpush(1, 8'h66, 1);
        check("irq_latency", {31'b0, irq}, 32'h0);
        @(posedge PCLK); #1;
        check("irq_set", {31'b0, irq}, 32'h1);
        rd(1, 0, 32'h66, "irq_pop");
        check("irq_hold", {31'b0, irq}, 32'h1);
        @(posedge PCLK); #1;
        check("irq_clr", {31'b0, irq}, 32'h0);
        wr(1, 3, 32'h0, "ctrl_off");
`else
        wr(1, 3, 32'h700, "ctrl_ignored");
        rd(1, 3, 32'h0, "ctrl_ro");
        hpush(1, 8'h66, 1);
        repeat (2) begin @(posedge PCLK); #1; end
        check("irq_tied", {31'b0, irq}, 32'h0);
        rd(1, 0, 32'h66, "pop66");
`endif

        // push+pop on empty H2D, then sticky set beating W1C
        fork
            rd(0, 0, 32'h0, "pop_push_empty");
            hpush(0, 8'h5A, 2);
        join
        rd(0, 1, 32'h07, "status_sim_empty");
        rd(0, 2, 32'h1, "level_one");
        hpush(0, 8'h5B, 1);
        hpush(0, 8'h5C, 1);
        hpush(0, 8'h5D, 1);
        fork
            wr(0, 3, 32'h14, "w1c_vs_set");
            hpush(0, 8'h5E, 2);
        join
        rd(0, 1, 32'h13, "set_wins");
        for (int i = 0; i < 4; i++) rd(0, 0, 32'h5A + 32'(i), "h2d_wrap");
        rd(0, 1, 32'h12, "status_end");

        repeat (3) @(posedge PCLK);
        #1;
        check("exp_q_drain", 32'(exp_q.size()), 32'd0);
        check("d2h_q_drain", 32'(d2h_q0.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/commfifo_mc_apb.md
COMMFIFO_MC_APB -- requirements
Module: commfifo_mc_apb

Interface
REQ-001 SHALL have parameter NCH, default 2, number of channels, range 1..4.
REQ-002 SHALL have parameter DW, default 8, data width in bits, range 8..32.
REQ-003 SHALL have parameter LGDEPTH, default 6, log2 FIFO depth per direction, range 2..8.
REQ-004 PCLK  in  1  clock; single clock domain, all state on rising edge.
REQ-005 PRESETn  in  1  synchronous active-low reset.
REQ-006 PSEL, PENABLE, PWRITE  in  1 each  APB control.
REQ-007 PADDR  in  [11:2]  word address.
REQ-008 PWDATA  in  32  write data; bits above DW ignored.
REQ-009 PRDATA  out  32  read data.
REQ-010 PREADY  out  1  tied 1.
REQ-011 PSLVERR  out  1  access error.
REQ-012 h2d_wr  in  NCH  per-channel host push strobe.
REQ-013 h2d_data  in  NCH*DW  host push data; channel c at [c*DW +: DW].
REQ-014 h2d_not_full  out  NCH  host may push.
REQ-015 d2h_rd  in  NCH  per-channel host pop strobe.
REQ-016 d2h_data  out  NCH*DW  head of each D2H FIFO, first-word-fall-through.
REQ-017 d2h_not_empty  out  NCH  D2H data valid.
REQ-018 irq  out  1  level interrupt.

Function
REQ-019 Each channel SHALL contain one H2D FIFO (host writes, APB reads) and one D2H FIFO (APB writes, host reads), each 2^LGDEPTH x DW, with LGDEPTH+1-bit counts.
REQ-020 Decode: channel = PADDR[5:4], register = PADDR[3:2]; access with PADDR[11:6]!=0 or channel>=NCH SHALL return PRDATA=0, have no side effect, and drive PSLVERR=1 in the access phase.
REQ-021 Reg 0 DATA: read SHALL return zero-extended H2D head and pop it; write SHALL push PWDATA[DW-1:0] to D2H.
REQ-022 Reg 1 STATUS (RO): bit0 H2D not empty, bit1 D2H not full, bit2 H2D underflow, bit3 D2H overflow, bit4 H2D host-overflow; others 0.
REQ-023 Reg 2 LEVEL (RO): [15:0] H2D count, [31:16] D2H count.
REQ-024 Reg 3 CTRL: write bits 2..4 =1 SHALL clear corresponding sticky bits (W1C); bits 8..10 R/W interrupt enables (rx-avail, tx-room, error); read returns enables at 8..10, 0 elsewhere.
REQ-025 Pop/push strobes SHALL act only in the access phase (PSEL&PENABLE), exactly once per transfer.
REQ-026 PRDATA SHALL be 0 except during a read access phase.
REQ-027 APB read of empty H2D SHALL return 0, not move pointers, set underflow sticky.
REQ-028 APB write to full D2H SHALL drop data and set overflow sticky; host push to full H2D SHALL drop and set host-overflow sticky; host pop of empty D2H SHALL be ignored.
REQ-029 Simultaneous push and pop on a full FIFO SHALL both succeed, count unchanged; on an empty FIFO only the push succeeds, count becomes 1.
REQ-030 Pointers SHALL wrap modulo 2^LGDEPTH; count SHALL reach exactly 2^LGDEPTH when full.
REQ-031 Status outputs and flags SHALL reflect the FIFO state one cycle after the causing edge; pushed data SHALL be visible at the head on the following cycle.
REQ-032 Sticky set and W1C clear in the same cycle: set SHALL win.

Reset
REQ-033 While PRESETn=0 at a PCLK edge: all pointers and counts 0, sticky bits 0, enables 0, irq 0; h2d_not_full=all 1, d2h_not_empty=0; FIFO RAM contents unspecified; reset mid-transfer SHALL discard the transfer.

Configuration
REQ-034 Macro COMMFIFO_MC_IRQ_EN defined: irq SHALL be registered OR over channels of (H2D not empty & en8) | (D2H not full & en9) | (any sticky & en10), one cycle latency.
REQ-035 Macro undefined: irq SHALL be tied 0, CTRL enable bits SHALL read 0 and ignore writes.

Verification
REQ-036 NCH=2,LGDEPTH=2: host pushes 0x11,0x22,0x33,0x44,0x55 on ch1 -> h2d_not_full=0 after 4th, LEVEL[15:0]=4, STATUS bit4=1; APB reads return 0x11..0x44 in order.
REQ-037 APB writes 0xA5 to ch0 DATA -> next cycle d2h_not_empty[0]=1, d2h_data[7:0]=0xA5; host pop -> d2h_not_empty[0]=0.
REQ-038 APB read ch0 DATA while empty -> PRDATA=0, STATUS=0x02|0x04; write CTRL 0x04 -> STATUS bit2=0.
REQ-039 Full D2H (count 4) with APB write and host pop same cycle -> count stays 4, new word at tail, no overflow flag.
REQ-040 Access PADDR=0x008 (channel 2) with NCH=2 -> PSLVERR=1, PRDATA=0, no state change.
REQ-041 With COMMFIFO_MC_IRQ_EN, CTRL ch1=0x100, host push ch1 -> irq=1 two cycles later; APB pop to empty -> irq=0 two cycles after pop.
